// File: rtl/riscv_fetch_buffer_pkg.sv
// Shared types for the instruction fetch buffer: FSM states, buffered entry layout
// and the reset fetch address.
package riscv_fetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    // PCs are word addresses, so the sequential successor is +1 and wraps silently.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/riscv_fetch_buffer_if.sv
// Fetch buffer bus bundle: instruction memory req/ack, core valid/ready and redirect.
// The master modport is the fetch buffer side; slave is memory/core side.
interface riscv_fetch_buffer_if;
    import riscv_fetch_buffer_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redir_valid, redir_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redir_valid, redir_pc
    );

endinterface

// File: rtl/riscv_fetch_buffer_sync_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush; flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module riscv_fetch_buffer_sync_fifo
    import riscv_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/riscv_fetch_buffer.sv
// Instruction fetch/prefetch buffer: one outstanding imem request, DEPTH-entry buffer, redirect flush.
// Define FETCH_PERF_EN to add perf_fetch_cnt / perf_flush_cnt counter ports.
module riscv_fetch_buffer
    import riscv_fetch_buffer_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic                  clk,
    input logic                  rst,
    riscv_fetch_buffer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic             push, pop, flush;
    fetch_entry_t     push_entry, head_entry;
    logic [CNT_W-1:0] count, count_after;
    logic             fifo_full, fifo_empty;

    // Ack data is only kept in REQ; acks in DROP or under a redirect are discarded.
    assign push        = (state_q == REQ) && bus.imem_ack && !bus.redir_valid;
    assign pop         = bus.instr_ready && !fifo_empty;
    assign flush       = bus.redir_valid;
    assign push_entry  = '{pc: fetch_pc_q, data: bus.imem_rdata};
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);

    riscv_fetch_buffer_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head_entry),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        fetch_pc_d  = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (bus.redir_valid) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = bus.redir_pc;
                    fetch_pc_d  = bus.redir_pc;
                end else if (!fifo_full || pop) begin
                    state_d     = REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end
            end
            REQ: begin
                if (bus.redir_valid) begin
                    fetch_pc_d = bus.redir_pc;
                    if (bus.imem_ack) begin
                        imem_addr_d = bus.redir_pc;
                    end else begin
                        state_d = DROP;
                    end
                end else if (bus.imem_ack) begin
                    fetch_pc_d = next_pc(fetch_pc_q);
                    // Issue the next request only if it still has a guaranteed buffer slot.
                    if (count_after < CNT_W'(DEPTH)) begin
                        imem_addr_d = next_pc(fetch_pc_q);
                    end else begin
                        state_d    = IDLE;
                        imem_req_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (bus.redir_valid) begin
                    fetch_pc_d = bus.redir_pc;
                end
                if (bus.imem_ack) begin
                    state_d     = REQ;
                    imem_addr_d = bus.redir_valid ? bus.redir_pc : fetch_pc_q;
                end
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_data  = fifo_empty ? '0 : head_entry.data;
    assign bus.instr_pc    = fifo_empty ? '0 : head_entry.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + (push ? 32'd1 : 32'd0);
        perf_flush_d = perf_flush_q + (bus.redir_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Scoreboard bench for riscv_fetch_buffer: a memory responder, a delivery monitor
// popping expected {pc,data} pairs, and directed scenarios with hand-computed timing.
module tb_riscv_fetch_buffer;

    logic clk;
    logic rst;

    riscv_fetch_buffer_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    riscv_fetch_buffer #(
        .DEPTH   (4),
        .RESET_PC(32'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    logic [63:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int ack_budget = 0;
    int ack_delay = 0;
    int ack_total = 0;
    int wait_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h5A5A_5A5A;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expectRange(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({base + 32'(i), memWord(base + 32'(i))});
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        ack_budget      = 0;
        settle();
        checkOutput("rst_req", 32'(bus.imem_req), 32'h0);
        checkOutput("rst_addr", bus.imem_addr, 32'h8000_0000);
        checkOutput("rst_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rst_pc", bus.instr_pc, 32'h0);
        checkOutput("rst_data", bus.instr_data, 32'h0);
        exp_q.delete();
    endtask

    // Releases reset; the cycle following this call is cycle 0.
    task automatic applyStimulus(input logic ready, input int delay, input int budget);
        bus.instr_ready = ready;
        ack_delay       = delay;
        ack_budget      = budget;
        ack_total       = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int max_cycles);
        int i = 0;
        while (exp_q.size() != 0 && i < max_cycles) begin
            tick();
            i++;
        end
        tick(5);
        settle();
        checkOutput(name, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    // Memory responder: acks a held request after ack_delay waiting cycles, within a budget.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                bus.imem_ack = 1'b0;
                wait_cnt     = 0;
            end else if (bus.imem_req && ack_budget > 0 && wait_cnt >= ack_delay) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = memWord(bus.imem_addr);
                ack_budget--;
                ack_total++;
                wait_cnt = 0;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = '0;
                if (bus.imem_req) wait_cnt++;
            end
        end
    end

    // Delivery monitor and request-stability checker.
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        logic [63:0] e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.instr_valid && bus.instr_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL deliver_unexpected: got pc %h data %h expected none",
                                 bus.instr_pc, bus.instr_data);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("deliver_pc", bus.instr_pc, e[63:32]);
                        checkOutput("deliver_data", bus.instr_data, e[31:0]);
                    end
                end
                if (prev_req && !prev_ack) begin
                    checkOutput("req_held", 32'(bus.imem_req), 32'h1);
                    checkOutput("addr_held", bus.imem_addr, prev_addr);
                end
                prev_req  = bus.imem_req;
                prev_ack  = bus.imem_ack;
                prev_addr = bus.imem_addr;
            end
        end
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;

        // Streaming: ack every cycle, ready held high.
        applyReset();
        expectRange(32'h8000_0000, 10);
        applyStimulus(1'b1, 0, 10);
        tick();
        settle();
        checkOutput("t1_req_c1", 32'(bus.imem_req), 32'h1);
        checkOutput("t1_addr_c1", bus.imem_addr, 32'h8000_0000);
        checkOutput("t1_valid_c1", 32'(bus.instr_valid), 32'h0);
        tick();
        settle();
        checkOutput("t1_valid_c2", 32'(bus.instr_valid), 32'h1);
        checkOutput("t1_pc_c2", bus.instr_pc, 32'h8000_0000);
        checkOutput("t1_data_c2", bus.instr_data, memWord(32'h8000_0000));
        tick(4);
        settle();
        checkOutput("t1_acks_c6", 32'(ack_total), 32'd6);
        checkOutput("t1_addr_c6", bus.imem_addr, 32'h8000_0005);
        waitDrain("t1_drain", 60);

        // Fill with ready low, then a single pop releases exactly one request.
        applyReset();
        applyStimulus(1'b0, 0, 100);
        tick(10);
        settle();
        checkOutput("t2_acks_full", 32'(ack_total), 32'd4);
        checkOutput("t2_req_full", 32'(bus.imem_req), 32'h0);
        checkOutput("t2_valid_full", 32'(bus.instr_valid), 32'h1);
        checkOutput("t2_pc_full", bus.instr_pc, 32'h8000_0000);
        tick();
        ack_budget = 1;
        expectRange(32'h8000_0000, 5);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        settle();
        checkOutput("t2_req_after_pop", 32'(bus.imem_req), 32'h1);
        checkOutput("t2_addr_after_pop", bus.imem_addr, 32'h8000_0004);
        tick(2);
        settle();
        checkOutput("t2_req_refull", 32'(bus.imem_req), 32'h0);
        checkOutput("t2_acks_refull", 32'(ack_total), 32'd5);
        tick();
        bus.instr_ready = 1'b1;
        waitDrain("t2_drain", 40);

        // Redirect while a request waits for a late ack.
        applyReset();
        expectRange(32'h8000_0100, 2);
        applyStimulus(1'b1, 3, 3);
        tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h8000_0100;
        tick();
        bus.redir_valid = 1'b0;
        settle();
        checkOutput("t3_req_drop", 32'(bus.imem_req), 32'h1);
        checkOutput("t3_addr_stale", bus.imem_addr, 32'h8000_0000);
        checkOutput("t3_valid_drop", 32'(bus.instr_valid), 32'h0);
        tick(3);
        settle();
        checkOutput("t3_addr_redir", bus.imem_addr, 32'h8000_0100);
        checkOutput("t3_req_redir", 32'(bus.imem_req), 32'h1);
        checkOutput("t3_acks_redir", 32'(ack_total), 32'd1);
        waitDrain("t3_drain", 40);

        // Redirect in the same cycle as an ack and a pop.
        applyReset();
        exp_q.push_back({32'h8000_0000, memWord(32'h8000_0000)});
        expectRange(32'h8000_0200, 2);
        applyStimulus(1'b1, 0, 4);
        tick(2);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h8000_0200;
        tick();
        bus.redir_valid = 1'b0;
        settle();
        checkOutput("t4_valid_flushed", 32'(bus.instr_valid), 32'h0);
        checkOutput("t4_data_flushed", bus.instr_data, 32'h0);
        checkOutput("t4_req_redir", 32'(bus.imem_req), 32'h1);
        checkOutput("t4_addr_redir", bus.imem_addr, 32'h8000_0200);
        waitDrain("t4_drain", 30);

        // Redirect to the top of the address space wraps to zero.
        applyReset();
        exp_q.push_back({32'hFFFF_FFFF, memWord(32'hFFFF_FFFF)});
        expectRange(32'h0000_0000, 2);
        applyStimulus(1'b1, 0, 3);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'hFFFF_FFFF;
        tick();
        bus.redir_valid = 1'b0;
        settle();
        checkOutput("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFF);
        checkOutput("t5_req_top", 32'(bus.imem_req), 32'h1);
        tick();
        settle();
        checkOutput("t5_addr_wrap", bus.imem_addr, 32'h0000_0000);
        waitDrain("t5_drain", 30);

        // Two redirects, the second while dropping; ten fetches accepted afterwards.
        applyReset();
        expectRange(32'h8000_0400, 10);
        applyStimulus(1'b1, 2, 11);
        tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h8000_0300;
        tick();
        bus.redir_pc    = 32'h8000_0400;
        tick();
        bus.redir_valid = 1'b0;
        settle();
        checkOutput("t6_addr_stale", bus.imem_addr, 32'h8000_0000);
        tick();
        settle();
        checkOutput("t6_addr_latest", bus.imem_addr, 32'h8000_0400);
        checkOutput("t6_req_latest", 32'(bus.imem_req), 32'h1);
        waitDrain("t6_drain", 120);
`ifdef FETCH_PERF_EN
        checkOutput("t6_perf_fetch", perf_fetch_cnt, 32'd10);
        checkOutput("t6_perf_flush", perf_flush_cnt, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
